// File: rtl/tour_monitor.sv
// tour_monitor: tracks a knight's tour on a BOARD_W x BOARD_H board and flags off-board, illegal or revisit moves.
module tour_monitor #(
  parameter int BOARD_W = 5,
  parameter int BOARD_H = 5,
  parameter int MOVES_REQ = BOARD_W*BOARD_H-1,
  parameter int MCW = $clog2(MOVES_REQ+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     start_xx,
  input  logic [2:0]     start_yy,
  input  logic           pos_vld,
  input  logic [2:0]     xx,
  input  logic [2:0]     yy,
  output logic [MCW-1:0] mv_cnt,
  output logic           move_ok,
  output logic           tour_done,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [2:0]     cur_xx,
  output logic [2:0]     cur_yy
);
  localparam int N = BOARD_W*BOARD_H;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, TRACK, DONE, ERR} state_t;
  state_t state, nxt_state;
  logic [N-1:0] vis, nxt_vis;
  logic [MCW-1:0] nxt_cnt;
  logic [1:0] nxt_code;
  logic [2:0] nxt_cx, nxt_cy;
  logic nxt_ok;
  logic s_on, p_on, legal, same;
  logic [IW-1:0] s_idx, p_idx;
  logic signed [3:0] dx, dy, ax, ay;
  function automatic logic [IW-1:0] idx_of(input logic [2:0] x, input logic [2:0] y);
    return IW'(int'(y)*BOARD_W + int'(x));
  endfunction
  assign s_on = (int'(start_xx) < BOARD_W) && (int'(start_yy) < BOARD_H);
  assign p_on = (int'(xx) < BOARD_W) && (int'(yy) < BOARD_H);
  assign s_idx = idx_of(start_xx, start_yy);
  assign p_idx = idx_of(xx, yy);
  assign dx = $signed({1'b0, xx}) - $signed({1'b0, cur_xx});
  assign dy = $signed({1'b0, yy}) - $signed({1'b0, cur_yy});
  assign ax = dx[3] ? -dx : dx;
  assign ay = dy[3] ? -dy : dy;
  assign legal = (ax == 4'sd1 && ay == 4'sd2) || (ax == 4'sd2 && ay == 4'sd1);
  assign same = (xx == cur_xx) && (yy == cur_yy);
  assign tour_done = (state == DONE);
  assign err = (state == ERR);
  always_comb begin
    nxt_state = state;
    nxt_vis = vis;
    nxt_cnt = mv_cnt;
    nxt_code = err_code;
    nxt_cx = cur_xx;
    nxt_cy = cur_yy;
    nxt_ok = 1'b0;
    if (start) begin
      nxt_vis = '0;
      nxt_cnt = '0;
      nxt_code = 2'd0;
      if (s_on) begin
        nxt_vis[s_idx] = 1'b1;
        nxt_cx = start_xx;
        nxt_cy = start_yy;
        nxt_state = TRACK;
      end else begin
        nxt_code = 2'd1;
        nxt_state = ERR;
      end
    end else if (pos_vld && state == TRACK && !same) begin
      if (!p_on || !legal || vis[p_idx]) begin
        nxt_code = !p_on ? 2'd1 : !legal ? 2'd2 : 2'd3;
        nxt_state = ERR;
      end else begin
        nxt_vis[p_idx] = 1'b1;
        nxt_cx = xx;
        nxt_cy = yy;
        nxt_cnt = mv_cnt + 1'b1;
        nxt_ok = 1'b1;
        nxt_state = (mv_cnt + 1'b1 == MCW'(MOVES_REQ)) ? DONE : TRACK;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vis <= '0;
      mv_cnt <= '0;
      err_code <= 2'd0;
      cur_xx <= 3'd0;
      cur_yy <= 3'd0;
      move_ok <= 1'b0;
    end else begin
      state <= nxt_state;
      vis <= nxt_vis;
      mv_cnt <= nxt_cnt;
      err_code <= nxt_code;
      cur_xx <= nxt_cx;
      cur_yy <= nxt_cy;
      move_ok <= nxt_ok;
    end
  end
endmodule

// File: tb/tb_tour_monitor.sv
// tb_tour_monitor: directed checks of tour_monitor on a 5x5 board, plus a short-tour instance for completion.
module tb_tour_monitor;
  logic clk = 0, rst = 1, start = 0, pos_vld = 0;
  logic [2:0] start_xx = 0, start_yy = 0, xx = 0, yy = 0;
  logic [4:0] mv_cnt;
  logic [1:0] mv_cnt2;
  logic move_ok, tour_done, err, move_ok2, tour_done2, err2;
  logic [1:0] err_code, err_code2;
  logic [2:0] cur_xx, cur_yy, cur_xx2, cur_yy2;
  int errors = 0, checks = 0;
  tour_monitor dut (
    .clk(clk), .rst(rst), .start(start), .start_xx(start_xx), .start_yy(start_yy),
    .pos_vld(pos_vld), .xx(xx), .yy(yy), .mv_cnt(mv_cnt), .move_ok(move_ok),
    .tour_done(tour_done), .err(err), .err_code(err_code), .cur_xx(cur_xx), .cur_yy(cur_yy)
  );
  tour_monitor #(.MOVES_REQ(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .start_xx(start_xx), .start_yy(start_yy),
    .pos_vld(pos_vld), .xx(xx), .yy(yy), .mv_cnt(mv_cnt2), .move_ok(move_ok2),
    .tour_done(tour_done2), .err(err2), .err_code(err_code2), .cur_xx(cur_xx2), .cur_yy(cur_yy2)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic go(input logic s, input logic p, input int sx, input int sy, input int px, input int py);
    @(negedge clk);
    start = s; pos_vld = p;
    start_xx = 3'(sx); start_yy = 3'(sy); xx = 3'(px); yy = 3'(py);
    @(negedge clk);
    start = 0; pos_vld = 0;
  endtask
  task automatic st(input int x, input int y);
    go(1, 0, x, y, 0, 0);
  endtask
  task automatic smp(input int x, input int y);
    go(0, 1, 0, 0, x, y);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_cnt", mv_cnt, 0);
    check("rst_ok", move_ok, 0);
    check("rst_done", tour_done, 0);
    check("rst_err", err, 0);
    check("rst_code", err_code, 0);
    check("rst_cur", {cur_xx, cur_yy}, 0);
    smp(1, 2);
    check("idle_ignore", mv_cnt, 0);
    st(2, 4);
    check("start_cur", {cur_xx, cur_yy}, {3'd2, 3'd4});
    check("start_err", err, 0);
    smp(0, 3);
    check("legal_ok", move_ok, 1);
    check("legal_cnt", mv_cnt, 1);
    check("legal_cur", {cur_xx, cur_yy}, {3'd0, 3'd3});
    check("legal_err", err, 0);
    @(negedge clk);
    check("ok_pulse", move_ok, 0);
    st(2, 4);
    check("restart_cnt", mv_cnt, 0);
    smp(3, 6);
    check("off_err", err, 1);
    check("off_code", err_code, 1);
    check("off_cur", {cur_xx, cur_yy}, {3'd2, 3'd4});
    check("off_cnt", mv_cnt, 0);
    st(2, 4);
    check("clr_err", err, 0);
    check("clr_code", err_code, 0);
    smp(2, 3);
    check("ill_code", err_code, 2);
    smp(0, 3);
    check("ill_ignore_cnt", mv_cnt, 0);
    check("ill_ignore_ok", move_ok, 0);
    check("ill_sticky", err_code, 2);
    st(2, 4);
    smp(0, 3);
    smp(2, 4);
    check("rev_cnt", mv_cnt, 1);
    check("rev_code", err_code, 3);
    check("rev_cur", {cur_xx, cur_yy}, {3'd0, 3'd3});
    st(2, 4);
    smp(2, 4);
    check("same_err", err, 0);
    check("same_cnt", mv_cnt, 0);
    smp(5, 0);
    check("off_x5_code", err_code, 1);
    st(0, 0);
    smp(1, 2);
    check("c_cnt1", mv_cnt2, 1);
    check("c_notdone", tour_done2, 0);
    smp(2, 0);
    check("c_done", tour_done2, 1);
    check("c_cnt2", mv_cnt2, 2);
    check("c_ok", move_ok2, 1);
    check("c_err", err2, 0);
    smp(0, 1);
    check("c_ignore_cnt", mv_cnt2, 2);
    check("c_ignore_ok", move_ok2, 0);
    check("c_still_done", tour_done2, 1);
    check("big_cnt", mv_cnt, 3);
    check("big_notdone", tour_done, 0);
    st(5, 0);
    check("soff_err", err, 1);
    check("soff_code", err_code, 1);
    st(4, 4);
    check("corner_err", err, 0);
    check("corner_cur", {cur_xx, cur_yy}, {3'd4, 3'd4});
    go(1, 1, 2, 4, 0, 3);
    check("prio_cnt", mv_cnt, 0);
    check("prio_cur", {cur_xx, cur_yy}, {3'd2, 3'd4});
    check("prio_ok", move_ok, 0);
    smp(0, 3);
    check("prio_next", mv_cnt, 1);
    @(negedge clk);
    rst = 1;
    pos_vld = 1; xx = 3'd1; yy = 3'd1;
    @(negedge clk);
    rst = 0; pos_vld = 0;
    check("mid_rst_cnt", mv_cnt, 0);
    check("mid_rst_cur", {cur_xx, cur_yy}, 0);
    check("mid_rst_ok", move_ok, 0);
    check("mid_rst_err", err, 0);
    smp(2, 1);
    check("post_rst_ignore", mv_cnt, 0);
    check("post_rst_ok", move_ok, 0);
    st(0, 0);
    smp(2, 1);
    check("resume_cnt", mv_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
